// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-source round-robin arbiter for the register-file write port (option: RF_WB_STALL_CNT_EN)
module rf_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    input  logic          stall_clr,
    output logic [15:0]   stall_cnt
);

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    logic          last_grant_q, last_grant_d;
    logic          grant_a, grant_b, any_grant;
    logic [AW-1:0] grant_addr;
    logic [DW-1:0] grant_data;

    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_wa_q, rf_wa_d;
    logic [DW-1:0] rf_wd_q, rf_wd_d;

    // Grant decision: a lone requester always wins; on contention the source
    // that did not win last time is served.
    always_comb begin
        grant_a    = a_valid && (!b_valid || (last_grant_q == SRC_B));
        grant_b    = b_valid && (!a_valid || (last_grant_q == SRC_A));
        any_grant  = grant_a || grant_b;
        grant_addr = grant_a ? a_addr : b_addr;
        grant_data = grant_a ? a_data : b_data;
        last_grant_d = last_grant_q;
        if (grant_a) begin
            last_grant_d = SRC_A;
        end else if (grant_b) begin
            last_grant_d = SRC_B;
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Next output-stage values: writes to the zero register are accepted but never enabled.
    always_comb begin
        rf_we_d = any_grant && (grant_addr != '0);
        rf_wa_d = rf_wa_q;
        rf_wd_d = rf_wd_q;
        if (any_grant) begin
            rf_wa_d = grant_addr;
            rf_wd_d = grant_data;
        end
    end

    // Arbitration history and registered write port; reset drops any in-flight write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= SRC_B;
            rf_we_q      <= 1'b0;
            rf_wa_q      <= '0;
            rf_wd_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_wa_q      <= rf_wa_d;
            rf_wd_q      <= rf_wd_d;
        end
    end

    assign rf_we = rf_we_q;
    assign rf_wa = rf_wa_q;
    assign rf_wd = rf_wd_q;

`ifdef RF_WB_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall_event;

    // Count cycles in which some requester was left waiting; clear overrides counting.
    always_comb begin
        stall_event = (a_valid && !grant_a) || (b_valid && !grant_b);
        stall_cnt_d = stall_cnt_q;
        if (stall_clr) begin
            stall_cnt_d = 16'h0000;
        end else if (stall_event && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'h0001;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic unused_stall_clr;
    assign unused_stall_clr = stall_clr;
    assign stall_cnt        = 16'h0000;
`endif

endmodule
